operand_buffer: RTL and testbench

OPERAND_BUFFER -- requirements
Module: operand_buffer

---
 rtl/operand_buffer.sv | 67 ++++++
 tb/tb_operand_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/operand_buffer.sv
// operand_buffer: LIFO/FIFO operand store with registered pop data and sticky overflow/underflow flags
module operand_buffer #(
  parameter int IN_W   = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              push,
  input  logic [IN_W-1:0]   push_data,
  input  logic              pop,
  input  logic              clear_err,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              have_data,
  output logic              overflow,
  output logic              underflow,
  output logic              mode_q
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wp, rp, top, waddr, raddr;
  logic eff, chg, do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign have_data = !empty;
  // an empty buffer adopts the requested mode immediately, so a push in that cycle lands where the new mode will read it
  always_comb begin
    eff = empty ? mode : mode_q;
    chg = eff != mode_q;
    wp = chg ? '0 : wr_ptr;
    rp = chg ? '0 : rd_ptr;
    top = PW'(count - CNT_W'(1));
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    waddr = eff ? wp : (do_pop ? top : count[PW-1:0]);
    raddr = eff ? rp : top;
  end
  always_ff @(posedge clk)
    if (!reset && do_push) mem[waddr] <= DATA_W'(push_data);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pop_data <= '0;
      pop_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      mode_q <= mode;
    end else begin
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      wr_ptr <= wp + PW'(do_push && eff);
      rd_ptr <= rp + PW'(do_pop && eff);
      pop_valid <= do_pop;
      if (do_pop) pop_data <= mem[raddr];
      overflow <= (overflow && !clear_err) || (push && full && !do_pop);
      underflow <= (underflow && !clear_err) || (pop && empty);
      mode_q <= eff;
    end
  end
endmodule

// File: tb/tb_operand_buffer.sv
// tb_operand_buffer: directed vector table plus randomized run against a queue-based reference model
module tb_operand_buffer;
  logic clk = 0, reset, mode, push, pop, clear_err;
  logic [15:0] push_data;
  logic [31:0] pop_data;
  logic [2:0] count;
  logic pop_valid, empty, full, have_data, overflow, underflow, mode_q;
  int checks = 0, errors = 0;

  operand_buffer #(.IN_W(16), .DATA_W(32), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .push(push), .push_data(push_data),
    .pop(pop), .clear_err(clear_err), .pop_data(pop_data), .pop_valid(pop_valid),
    .count(count), .empty(empty), .full(full), .have_data(have_data),
    .overflow(overflow), .underflow(underflow), .mode_q(mode_q));

  always #5 clk = ~clk;

  typedef struct {
    logic rst, md, ps;
    logic [15:0] pd;
    logic pp, clr;
    logic [2:0] cnt;
    logic pv;
    logic [31:0] pdo;
    logic ov, un, mq;
  } vec_t;
  vec_t tab[$];

  function automatic void add(bit r, bit m, bit p, int d, bit q, bit c,
                              int n, bit v, int o, bit ov, bit un, bit mq);
    vec_t t;
    t.rst = r; t.md = m; t.ps = p; t.pd = 16'(d); t.pp = q; t.clr = c;
    t.cnt = 3'(n); t.pv = v; t.pdo = 32'(o); t.ov = ov; t.un = un; t.mq = mq;
    tab.push_back(t);
  endfunction

  function automatic logic [41:0] pack(int n, bit v, logic [31:0] d, bit ov, bit un, bit mq);
    return {3'(n), v, d, ov, un, mq, n == 0, n == 4, n > 0};
  endfunction

  task automatic chk(string name, logic [41:0] exp);
    logic [41:0] act;
    act = {count, pop_valid, pop_data, overflow, underflow, mode_q, empty, full, have_data};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d pv=%0b pd=%h ov=%0b un=%0b mq=%0b e/f/h=%0b%0b%0b want cnt=%0d pv=%0b pd=%h ov=%0b un=%0b mq=%0b e/f/h=%0b%0b%0b",
        name, act[41:39], act[38], act[37:6], act[5], act[4], act[3], act[2], act[1], act[0],
        exp[41:39], exp[38], exp[37:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(bit r, bit m, bit p, logic [15:0] d, bit q, bit c);
    reset = r; mode = m; push = p; push_data = d; pop = q; clear_err = c;
  endtask

  logic [31:0] mq_q[$];
  logic m_pv, m_ov, m_un, m_mq;
  logic [31:0] m_pd;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    add(1,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,1,1,0,0, 1,0,0,0,0,0);
    add(0,0,1,2,0,0, 2,0,0,0,0,0);
    add(0,0,1,3,0,0, 3,0,0,0,0,0);
    add(0,0,0,0,1,0, 2,1,3,0,0,0);
    add(0,0,0,0,1,0, 1,1,2,0,0,0);
    add(0,0,0,0,1,0, 0,1,1,0,0,0);
    add(0,1,1,'hA,0,0, 1,0,1,0,0,1);
    add(0,1,1,'hB,0,0, 2,0,1,0,0,1);
    add(0,1,1,'hC,0,0, 3,0,1,0,0,1);
    add(0,1,1,'hD,0,0, 4,0,1,0,0,1);
    add(0,1,1,'hE,0,0, 4,0,1,1,0,1);
    add(0,1,0,0,1,0, 3,1,'hA,1,0,1);
    add(0,1,0,0,1,0, 2,1,'hB,1,0,1);
    add(0,1,0,0,1,0, 1,1,'hC,1,0,1);
    add(0,1,0,0,1,0, 0,1,'hD,1,0,1);
    add(0,1,0,0,1,0, 0,0,'hD,1,1,1);
    add(0,1,0,0,0,1, 0,0,'hD,0,0,1);
    for (int i = 1; i <= 4; i++) add(0,0,1,i,0,0, i,0,'hD,0,0,0);
    add(0,0,1,9,1,0, 4,1,4,0,0,0);
    add(0,0,0,0,1,0, 3,1,9,0,0,0);
    add(0,0,0,0,1,0, 2,1,3,0,0,0);
    add(0,0,0,0,1,0, 1,1,2,0,0,0);
    add(0,0,0,0,1,0, 0,1,1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,'h10+i,0,0, i+1,0,1,0,0,1);
    for (int i = 0; i < 10; i++) add(0,1,1,'h13+i,1,0, 3,1,'h10+i,0,0,1);
    add(0,0,0,0,1,0, 2,1,'h1A,0,0,1);
    add(0,0,0,0,1,0, 1,1,'h1B,0,0,1);
    add(0,0,0,0,1,0, 0,1,'h1C,0,0,1);
    add(0,0,0,0,0,0, 0,0,'h1C,0,0,0);
    add(0,0,0,0,1,0, 0,0,'h1C,0,1,0);
    for (int i = 1; i <= 3; i++) add(0,0,1,i,0,0, i,0,'h1C,0,1,0);
    add(1,0,1,7,1,0, 0,0,0,0,0,0);
    add(0,0,0,0,1,1, 0,0,0,0,1,0);
    add(0,0,0,0,0,1, 0,0,0,0,0,0);
    add(0,0,1,'h55,1,0, 1,0,0,0,1,0);
    add(0,0,0,0,1,0, 0,1,'h55,0,1,0);
    for (int i = 1; i <= 4; i++) add(0,0,1,i,0,0, i,0,'h55,0,1,0);
    add(0,0,1,5,0,1, 4,0,'h55,1,0,0);
    add(1,1,0,0,0,0, 0,0,0,0,0,1);
    foreach (tab[i]) begin
      drive(tab[i].rst, tab[i].md, tab[i].ps, tab[i].pd, tab[i].pp, tab[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), pack(tab[i].cnt, tab[i].pv, tab[i].pdo, tab[i].ov, tab[i].un, tab[i].mq));
    end
    m_mq = 1;
    for (int c = 0; c < 800; c++) begin
      bit r, m, p, q, cl;
      logic [15:0] d;
      int n;
      logic [31:0] w;
      bit popok, ovev, unev;
      r = ($urandom_range(63) == 0);
      m = ($urandom_range(7) == 0) ? !mode : mode;
      p = ($urandom_range(99) < 55);
      q = ($urandom_range(99) < 45);
      cl = ($urandom_range(15) == 0);
      d = 16'($urandom);
      drive(r, m, p, d, q, cl);
      if (r) begin
        mq_q.delete();
        m_pd = 0; m_pv = 0; m_ov = 0; m_un = 0; m_mq = m;
      end else begin
        n = mq_q.size();
        if (n == 0) m_mq = m;
        popok = q && n > 0;
        m_pv = popok;
        if (popok) begin
          w = m_mq ? mq_q.pop_front() : mq_q.pop_back();
          m_pd = w;
        end
        ovev = p && n == 4 && !popok;
        if (p && !ovev) mq_q.push_back({16'h0, d});
        unev = q && n == 0;
        m_ov = (m_ov && !cl) || ovev;
        m_un = (m_un && !cl) || unev;
      end
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d", c), pack(mq_q.size(), m_pv, m_pd, m_ov, m_un, m_mq));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
